// File: rtl/issue_arbiter_pkg.sv
// Shared definitions for the issue arbiter: issue-FIFO entry field offsets,
// source-queue encoding and a saturating counter helper.
package issue_arbiter_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_Q1   = 2'd1,
        SRC_Q2   = 2'd2,
        SRC_Q3   = 2'd3
    } src_e;

    // Entry layout from MSB down: lkp_en | info | odr_id | so | payload
    function automatic int so_bit_f(input int data_length);
        return data_length;
    endfunction

    function automatic int odr_lsb_f(input int data_length);
        return data_length + 1;
    endfunction

    function automatic int info_lsb_f(input int order_id, input int data_length);
        return data_length + 1 + order_id;
    endfunction

    function automatic int lkp_en_bit_f(input int info_length, input int order_id,
                                        input int data_length);
        return data_length + 1 + order_id + info_length;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/issue_chan_reg.sv
// One output channel: registered valid/ready stage fed by a 2-way round-robin
// choice between candidate A (preferred after reset) and candidate B.
module issue_chan_reg
    import issue_arbiter_pkg::*;
#(
    parameter int   W     = 8,
    parameter src_e SRC_A = SRC_Q1,
    parameter src_e SRC_B = SRC_Q3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cand_a,
    input  logic [W-1:0] ent_a,
    input  logic         cand_b,
    input  logic [W-1:0] ent_b,
    input  logic         rdy,
    output logic         gnt_a,
    output logic         gnt_b,
    output logic         vld,
    output logic [W-1:0] ent,
    output logic [1:0]   src
);

    logic         vld_q, vld_d;
    logic [W-1:0] ent_q, ent_d;
    src_e         src_q, src_d;
    logic         ptr_q, ptr_d;
    logic         free;

    always_comb begin
        free  = ~vld_q | rdy;
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst && free) begin
            if (cand_a && (!ptr_q || !cand_b)) gnt_a = 1'b1;
            else if (cand_b)                   gnt_b = 1'b1;
        end

        vld_d = vld_q;
        ent_d = ent_q;
        src_d = src_q;
        ptr_d = ptr_q;
        // The pointer always moves away from whoever was just served
        if (gnt_a) begin
            vld_d = 1'b1;
            ent_d = ent_a;
            src_d = SRC_A;
            ptr_d = 1'b1;
        end else if (gnt_b) begin
            vld_d = 1'b1;
            ent_d = ent_b;
            src_d = SRC_B;
            ptr_d = 1'b0;
        end else if (rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            ent_q <= '0;
            src_q <= SRC_NONE;
            ptr_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            ent_q <= ent_d;
            src_q <= src_d;
            ptr_q <= ptr_d;
        end
    end

    assign vld = vld_q;
    assign ent = ent_q;
    assign src = src_q;

endmodule

// File: rtl/issue_arbiter.sv
// Drains the three issue FIFOs onto the lookup and bypass channels.
// Optional ISSUE_PERF_CNT_EN adds saturating grant and stall counters.
module issue_arbiter
    import issue_arbiter_pkg::*;
#(
    parameter int  info_length  = 20,
    parameter int  order_id     = 3,
    parameter int  data_length  = 512,
    localparam int buffer_width = 1 + info_length + order_id + 1 + data_length
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [buffer_width-1:0] fifo_1_out,
    input  logic                    empty_1,
    output logic                    rd_1,
    input  logic [buffer_width-1:0] fifo_2_out,
    input  logic                    empty_2,
    output logic                    rd_2,
    input  logic [buffer_width-1:0] fifo_3_out,
    input  logic                    empty_3,
    output logic                    rd_3,
    output logic                    lkp_vld,
    input  logic                    lkp_rdy,
    output logic [info_length-1:0]  lkp_info,
    output logic [order_id-1:0]     lkp_odr_id,
    output logic                    lkp_so,
    output logic [data_length-1:0]  lkp_payload,
    output logic [1:0]              lkp_src,
    output logic                    byp_vld,
    input  logic                    byp_rdy,
    output logic [order_id-1:0]     byp_odr_id,
    output logic                    byp_so,
    output logic [data_length-1:0]  byp_payload,
    output logic [1:0]              byp_src
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]             grant_cnt_1,
    output logic [31:0]             grant_cnt_2,
    output logic [31:0]             grant_cnt_3,
    output logic [31:0]             stall_cnt_lkp,
    output logic [31:0]             stall_cnt_byp
`endif
);

    localparam int LKP_EN_BIT = lkp_en_bit_f(info_length, order_id, data_length);
    localparam int INFO_LSB   = info_lsb_f(order_id, data_length);
    localparam int ODR_LSB    = odr_lsb_f(data_length);
    localparam int SO_BIT     = so_bit_f(data_length);

    logic                    q3_to_lkp, q3_to_byp;
    logic                    lkp_gnt_q2, lkp_gnt_q3, byp_gnt_q1, byp_gnt_q3;
    logic [buffer_width-1:0] lkp_ent, byp_ent;
    logic                    unused_fields;

    // Q3 head alone decides where Q3 goes, so it never competes on both channels
    assign q3_to_lkp = ~empty_3 &  fifo_3_out[LKP_EN_BIT];
    assign q3_to_byp = ~empty_3 & ~fifo_3_out[LKP_EN_BIT];

    issue_chan_reg #(.W(buffer_width), .SRC_A(SRC_Q2), .SRC_B(SRC_Q3)) u_lkp (
        .clk    (clk),
        .rst    (rst),
        .cand_a (~empty_2),
        .ent_a  (fifo_2_out),
        .cand_b (q3_to_lkp),
        .ent_b  (fifo_3_out),
        .rdy    (lkp_rdy),
        .gnt_a  (lkp_gnt_q2),
        .gnt_b  (lkp_gnt_q3),
        .vld    (lkp_vld),
        .ent    (lkp_ent),
        .src    (lkp_src)
    );

    issue_chan_reg #(.W(buffer_width), .SRC_A(SRC_Q1), .SRC_B(SRC_Q3)) u_byp (
        .clk    (clk),
        .rst    (rst),
        .cand_a (~empty_1),
        .ent_a  (fifo_1_out),
        .cand_b (q3_to_byp),
        .ent_b  (fifo_3_out),
        .rdy    (byp_rdy),
        .gnt_a  (byp_gnt_q1),
        .gnt_b  (byp_gnt_q3),
        .vld    (byp_vld),
        .ent    (byp_ent),
        .src    (byp_src)
    );

    assign rd_1 = byp_gnt_q1;
    assign rd_2 = lkp_gnt_q2;
    assign rd_3 = lkp_gnt_q3 | byp_gnt_q3;

    assign lkp_info    = lkp_ent[LKP_EN_BIT-1:INFO_LSB];
    assign lkp_odr_id  = lkp_ent[INFO_LSB-1:ODR_LSB];
    assign lkp_so      = lkp_ent[SO_BIT];
    assign lkp_payload = lkp_ent[data_length-1:0];
    assign byp_odr_id  = byp_ent[INFO_LSB-1:ODR_LSB];
    assign byp_so      = byp_ent[SO_BIT];
    assign byp_payload = byp_ent[data_length-1:0];

    assign unused_fields = ^{lkp_ent[LKP_EN_BIT], byp_ent[LKP_EN_BIT:INFO_LSB]};

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] gcnt_1_q, gcnt_1_d, gcnt_2_q, gcnt_2_d, gcnt_3_q, gcnt_3_d;
    logic [31:0] scnt_lkp_q, scnt_lkp_d, scnt_byp_q, scnt_byp_d;

    always_comb begin
        gcnt_1_d   = rd_1 ? sat_inc(gcnt_1_q) : gcnt_1_q;
        gcnt_2_d   = rd_2 ? sat_inc(gcnt_2_q) : gcnt_2_q;
        gcnt_3_d   = rd_3 ? sat_inc(gcnt_3_q) : gcnt_3_q;
        scnt_lkp_d = (lkp_vld & ~lkp_rdy) ? sat_inc(scnt_lkp_q) : scnt_lkp_q;
        scnt_byp_d = (byp_vld & ~byp_rdy) ? sat_inc(scnt_byp_q) : scnt_byp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt_1_q   <= '0;
            gcnt_2_q   <= '0;
            gcnt_3_q   <= '0;
            scnt_lkp_q <= '0;
            scnt_byp_q <= '0;
        end else begin
            gcnt_1_q   <= gcnt_1_d;
            gcnt_2_q   <= gcnt_2_d;
            gcnt_3_q   <= gcnt_3_d;
            scnt_lkp_q <= scnt_lkp_d;
            scnt_byp_q <= scnt_byp_d;
        end
    end

    assign grant_cnt_1   = gcnt_1_q;
    assign grant_cnt_2   = gcnt_2_q;
    assign grant_cnt_3   = gcnt_3_q;
    assign stall_cnt_lkp = scnt_lkp_q;
    assign stall_cnt_byp = scnt_byp_q;
`endif

endmodule
